// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared CPU-slice definitions.
// Provides the datapath width, the divider iteration count and the divider
// FSM state type used by divider64.
`timescale 1ns/1ps
package cpu_pkg;
  localparam int WIDTH     = 64;
  localparam int DIV_ITERS = 64;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/subtractor64.sv
// subtractor64 -- 64-bit subtractor, diff = a - b.
// Ports:
//   a, b      : operands
//   diff      : a - b mod 2^64
//   cout      : 1 when no borrow (a >= b unsigned)
//   overflow  : two's-complement overflow of the subtraction
`timescale 1ns/1ps
module subtractor64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] diff,
  output logic        cout,
  output logic        overflow
);
  assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + 65'd1;
  assign overflow     = (a[63] ^ b[63]) & (a[63] ^ diff[63]);
endmodule

// File: rtl/divider64.sv
// divider64 -- iterative restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start               : request, sampled only in IDLE
//   signed_op           : two's-complement divide (signed build only)
//   dividend, divisor   : operands, captured on accepted start
//   busy                : high in RUN and DONE
//   done                : one-cycle pulse, results valid
//   quotient, remainder : results, held until the next operation completes
//   div_by_zero         : divisor was zero for the last operation
// Build option: define DIVIDER64_SIGNED_DIV_EN to add signed division.
// Timing: accept edge E0, iterations on E1..E64, results land on E64 (entry
// to DONE), done pulses after E65 while the FSM is back in IDLE.
`timescale 1ns/1ps
module divider64 #(
  parameter int WIDTH = cpu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import cpu_pkg::*;

  div_state_e           state, state_nxt;
  logic [DIV_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]     rem_q;   // partial remainder
  logic [WIDTH-1:0]     dq_q;    // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]     dsr_q;

  logic [WIDTH-1:0] shifted, sub_diff, rem_nxt, quo_nxt, q_fin, r_fin;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic             sub_cout, sub_ovf_unused, take, cnt_last, accept, dsr_zero;

  assign accept   = (state == DIV_IDLE) & start;
  assign dsr_zero = (divisor == '0);
  assign cnt_last = (cnt == DIV_CNT_W'(DIV_ITERS-1));
  assign busy     = (state != DIV_IDLE);

  assign shifted = {rem_q[WIDTH-2:0], dq_q[WIDTH-1]};

  subtractor64 u_sub (
    .a       (shifted),
    .b       (dsr_q),
    .diff    (sub_diff),
    .cout    (sub_cout),
    .overflow(sub_ovf_unused)
  );

  // A set MSB in rem_q means the shifted value is really 65 bits wide and
  // exceeds any divisor, so the subtract must be kept even though the
  // 64-bit subtractor reports a borrow.
  assign take    = sub_cout | rem_q[WIDTH-1];
  assign rem_nxt = take ? sub_diff : shifted;
  assign quo_nxt = {dq_q[WIDTH-2:0], take};

`ifdef DIVIDER64_SIGNED_DIV_EN
  logic dvd_neg, dsr_neg, neg_q, neg_r;
  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dsr_neg = signed_op & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dsr_mag = dsr_neg ? -divisor  : divisor;
  // Most-negative / -1 needs no special case: magnitudes give 2^63 / 1 and
  // negating 2^63 wraps back to itself.
  assign q_fin   = neg_q ? -quo_nxt : quo_nxt;
  assign r_fin   = neg_r ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dvd_neg ^ dsr_neg;
      neg_r <= dvd_neg;
    end
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign dvd_mag = dividend;
  assign dsr_mag = divisor;
  assign q_fin   = quo_nxt;
  assign r_fin   = rem_nxt;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_IDLE: if (start) state_nxt = dsr_zero ? DIV_DONE : DIV_RUN;
      DIV_RUN:  if (cnt_last) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DIV_IDLE;
      done        <= 1'b0;
      cnt         <= '0;
      rem_q       <= '0;
      dq_q        <= '0;
      dsr_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DIV_DONE);
      if (accept) begin
        cnt   <= '0;
        rem_q <= '0;
        dq_q  <= dvd_mag;
        dsr_q <= dsr_mag;
        // Zero divisor skips RUN entirely; results land on this edge.
        if (dsr_zero) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (state == DIV_RUN) begin
        cnt   <= cnt + 1'b1;
        rem_q <= rem_nxt;
        dq_q  <= quo_nxt;
        if (cnt_last) begin
          quotient    <= q_fin;
          remainder   <= r_fin;
          div_by_zero <= 1'b0;
        end
      end
    end
  end
endmodule
